// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the single-cycle data memory port.
// Accepts load/store/copy commands over valid/ready and drives the memory port.
module mem_access_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [1:0]        i_cmd_op,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [ADDR_W-1:0] i_cmd_addr2,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  input  logic [LEN_W-1:0]  i_cmd_len,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_done,
  output logic              o_err,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_write,
  output logic              o_mem_write_en,
  output logic              o_mem_read,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  // state    | meaning
  // S_IDLE   | ready for a command, memory port parked at zero
  // S_LOAD   | single read cycle, data captured at its closing edge
  // S_STORE  | single write cycle
  // S_CP_RD  | copy: read source word src+i
  // S_CP_WR  | copy: write buffered word to dst+i, advance i
  // S_FIN    | completion pulse cycle (done, rsp_valid, err)
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STORE, S_CP_RD, S_CP_WR, S_FIN
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_cmd_ready;
  logic                r_busy;
  logic                r_rsp_valid;
  logic                r_done;
  logic                r_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_write;
  logic                r_mem_we;
  logic                r_mem_re;

  logic                w_accept;
  logic [LEN_W-1:0]    w_idx_next;
  logic [ADDR_W-1:0]   w_rd_next_addr;
  logic [ADDR_W-1:0]   w_wr_addr;

  assign w_accept       = i_cmd_valid & r_cmd_ready;
  assign w_idx_next     = r_idx + 1'b1;
  assign w_rd_next_addr = r_src + ADDR_W'(w_idx_next);
  assign w_wr_addr      = r_dst + ADDR_W'(r_idx);

  // Outputs are registered one state ahead, so each access cycle sees its
  // address/strobes from the edge that entered it. The write data register
  // doubles as the copy buffer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_rsp_data  <= '0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_write <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_write <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src       <= i_cmd_addr;
            r_dst       <= i_cmd_addr2;
            r_len       <= i_cmd_len;
            r_idx       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            case (i_cmd_op)
              OP_LOAD: begin
                r_state    <= S_LOAD;
                r_mem_re   <= 1'b1;
                r_mem_addr <= i_cmd_addr;
              end
              OP_STORE: begin
                r_state     <= S_STORE;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= i_cmd_addr;
                r_mem_write <= i_cmd_wdata;
              end
              OP_COPY: begin
                if (i_cmd_len != '0) begin
                  r_state    <= S_CP_RD;
                  r_mem_re   <= 1'b1;
                  r_mem_addr <= i_cmd_addr;
                end else begin
                  r_state <= S_FIN;
                  r_done  <= 1'b1;
                end
              end
              default: begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          r_rsp_data  <= i_mem_read_data;
          r_state     <= S_FIN;
          r_done      <= 1'b1;
          r_rsp_valid <= 1'b1;
        end
        S_STORE: begin
          r_state <= S_FIN;
          r_done  <= 1'b1;
        end
        S_CP_RD: begin
          r_state     <= S_CP_WR;
          r_mem_we    <= 1'b1;
          r_mem_addr  <= w_wr_addr;
          r_mem_write <= i_mem_read_data;
        end
        S_CP_WR: begin
          r_idx <= w_idx_next;
          if (w_idx_next == r_len) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_CP_RD;
            r_mem_re   <= 1'b1;
            r_mem_addr <= w_rd_next_addr;
          end
        end
        S_FIN: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = r_busy;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_write = r_mem_write;
  // Reset suppresses strobes in the cycle it is asserted, so an aborted copy
  // cannot land one more word at the reset edge.
  assign o_mem_write_en = r_mem_we & ~i_rst;
  assign o_mem_read     = r_mem_re & ~i_rst;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 64K-word data memory.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_addr2;
  logic [15:0] cmd_wdata;
  logic [4:0]  cmd_len;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        done;
  logic        err;
  logic        busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_write;
  logic        mem_write_en;
  logic        mem_read;
  logic [15:0] mem_read_data;

  logic [15:0] ram [0:65535];

  int total = 0;
  int bad   = 0;

  int          wr_cnt, rd_cnt, overlap_cnt, done_cnt, err_cnt;
  logic [15:0] rd_q[$];
  logic [15:0] wr_q[$];

  mem_access_ctrl dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_op        (cmd_op),
    .i_cmd_addr      (cmd_addr),
    .i_cmd_addr2     (cmd_addr2),
    .i_cmd_wdata     (cmd_wdata),
    .i_cmd_len       (cmd_len),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_data      (rsp_data),
    .o_done          (done),
    .o_err           (err),
    .o_busy          (busy),
    .o_mem_addr      (mem_addr),
    .o_mem_write     (mem_write),
    .o_mem_write_en  (mem_write_en),
    .o_mem_read      (mem_read),
    .i_mem_read_data (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = ram[mem_addr];

  always @(posedge clk) begin
    if (mem_write_en) ram[mem_addr] = mem_write;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write_en) begin wr_cnt++; wr_q.push_back(mem_addr); end
      if (mem_read)     begin rd_cnt++; rd_q.push_back(mem_addr); end
      if (mem_write_en && mem_read) overlap_cnt++;
      if (done) done_cnt++;
      if (err)  err_cnt++;
    end
  end

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; overlap_cnt = 0; done_cnt = 0; err_cnt = 0;
    rd_q.delete(); wr_q.delete();
  endtask

  // Drives a command and returns 1ns after its accept edge (first cycle of the command).
  task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] a2,
                       input logic [15:0] wd, input logic [4:0] len);
    int n = 0;
    cmd_op = op; cmd_addr = a; cmd_addr2 = a2; cmd_wdata = wd; cmd_len = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL issue_timeout cmd_ready=%b required=1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if ({cmd_ready, busy, rsp_valid, done, err} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctl got=%b required=10000", {cmd_ready, busy, rsp_valid, done, err});
    end
    total++;
    if ({mem_addr, mem_write, mem_write_en, mem_read} !== 34'h0) begin
      bad++; $display("FAIL reset_mem addr=%h wdata=%h we=%b re=%b required all 0",
                      mem_addr, mem_write, mem_write_en, mem_read);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    clear_mon();
    issue(2'b01, 16'h0007, 16'h0000, 16'h1234, 5'd0);
    total++;
    if ({mem_write_en, mem_read, mem_addr, mem_write, cmd_ready} !== {1'b1, 1'b0, 16'h0007, 16'h1234, 1'b0}) begin
      bad++; $display("FAIL store_cycle we=%b re=%b addr=%h wdata=%h ready=%b required 1 0 0007 1234 0",
                      mem_write_en, mem_read, mem_addr, mem_write, cmd_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({done, rsp_valid, err, ram[7]} !== {3'b100, 16'h1234}) begin
      bad++; $display("FAIL store_fin done=%b rsp_valid=%b err=%b ram7=%h required 1 0 0 1234",
                      done, rsp_valid, err, ram[7]);
    end
    @(posedge clk); #1;
    issue(2'b00, 16'h0007, 16'h0000, 16'h0000, 5'd0);
    total++;
    if ({mem_read, mem_write_en, mem_addr} !== {1'b1, 1'b0, 16'h0007}) begin
      bad++; $display("FAIL load_cycle re=%b we=%b addr=%h required 1 0 0007", mem_read, mem_write_en, mem_addr);
    end
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, done, err, rsp_data} !== {3'b110, 16'h1234}) begin
      bad++; $display("FAIL load_fin rsp_valid=%b done=%b err=%b rsp_data=%h required 1 1 0 1234",
                      rsp_valid, done, err, rsp_data);
    end
    @(posedge clk); #1;
    total++;
    if ({cmd_ready, rsp_valid, done, rsp_data} !== {3'b100, 16'h1234}) begin
      bad++; $display("FAIL load_after ready=%b rsp_valid=%b done=%b rsp_data=%h required 1 0 0 1234",
                      cmd_ready, rsp_valid, done, rsp_data);
    end
    total++;
    if (wr_cnt !== 1 || wr_q[0] !== 16'h0007 || rd_cnt !== 1 || done_cnt !== 2) begin
      bad++; $display("FAIL store_load_counts wr=%0d rd=%0d done=%0d required 1 1 2", wr_cnt, rd_cnt, done_cnt);
    end
  endtask

  task automatic test_copy();
    int done_cyc = 0;
    int pat_err = 0;
    for (int k = 0; k < 4; k++) begin ram[k] = 16'(k + 1); ram[8 + k] = 16'h0; end
    clear_mon();
    issue(2'b10, 16'h0000, 16'h0008, 16'h0000, 5'd4);
    for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
      if (done) done_cyc = c;
      else if (mem_read !== c[0] || mem_write_en !== !c[0]) pat_err++;
      @(posedge clk); #1;
    end
    total++;
    if (done_cyc !== 9 || pat_err !== 0) begin
      bad++; $display("FAIL copy_timing done_cycle=%0d pattern_errs=%0d required 9 0", done_cyc, pat_err);
    end
    total++;
    if ({ram[8], ram[9], ram[10], ram[11]} !== {16'd1, 16'd2, 16'd3, 16'd4}) begin
      bad++; $display("FAIL copy_data got=%h %h %h %h required 1 2 3 4", ram[8], ram[9], ram[10], ram[11]);
    end
    total++;
    if (rd_cnt !== 4 || wr_cnt !== 4 || overlap_cnt !== 0 || err_cnt !== 0) begin
      bad++; $display("FAIL copy_counts rd=%0d wr=%0d overlap=%0d err=%0d required 4 4 0 0",
                      rd_cnt, wr_cnt, overlap_cnt, err_cnt);
    end
  endtask

  task automatic test_zero_len_reserved();
    clear_mon();
    issue(2'b10, 16'h0003, 16'h0040, 16'h0000, 5'd0);
    total++;
    if ({done, err, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL zero_len_fin done=%b err=%b rsp_valid=%b required 100", done, err, rsp_valid);
    end
    @(posedge clk); #1;
    issue(2'b11, 16'h0005, 16'h0000, 16'h0000, 5'd0);
    total++;
    if ({done, err, rsp_valid} !== 3'b110) begin
      bad++; $display("FAIL reserved_fin done=%b err=%b rsp_valid=%b required 110", done, err, rsp_valid);
    end
    @(posedge clk); #1;
    total++;
    if (rd_cnt !== 0 || wr_cnt !== 0 || done_cnt !== 2 || err_cnt !== 1 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL zero_res_counts rd=%0d wr=%0d done=%0d err=%0d ready=%b required 0 0 2 1 1",
                      rd_cnt, wr_cnt, done_cnt, err_cnt, cmd_ready);
    end
  endtask

  task automatic test_wrap();
    int n = 0;
    ram[16'hFFFE] = 16'h000A; ram[16'hFFFF] = 16'h000B; ram[0] = 16'h000C;
    clear_mon();
    issue(2'b10, 16'hFFFE, 16'h0004, 16'h0000, 5'd3);
    while (!done && n < 30) begin @(posedge clk); #1; n++; end
    total++;
    if (n !== 6) begin
      bad++; $display("FAIL wrap_done cycles_to_done=%0d required 6", n);
    end
    total++;
    if (rd_q.size() !== 3 || rd_q[0] !== 16'hFFFE || rd_q[1] !== 16'hFFFF || rd_q[2] !== 16'h0000) begin
      bad++; $display("FAIL wrap_rd_addrs n=%0d first=%h required 3 FFFE FFFF 0000", rd_q.size(), rd_q[0]);
    end
    total++;
    if ({ram[4], ram[5], ram[6]} !== {16'hA, 16'hB, 16'hC}) begin
      bad++; $display("FAIL wrap_data got=%h %h %h required 000a 000b 000c", ram[4], ram[5], ram[6]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_copy();
    for (int k = 0; k < 4; k++) begin ram[k] = 16'(k + 1); ram[16'h20 + k] = 16'h0; end
    clear_mon();
    issue(2'b10, 16'h0000, 16'h0020, 16'h0000, 5'd4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if ({mem_write_en, mem_addr} !== {1'b1, 16'h0021}) begin
      bad++; $display("FAIL mid_second_wr we=%b addr=%h required 1 0021", mem_write_en, mem_addr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({cmd_ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL mid_after_reset ready=%b busy=%b done=%b required 100", cmd_ready, busy, done);
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (wr_cnt !== 1 || ram[16'h20] !== 16'd1 || ram[16'h21] !== 16'd0 || done_cnt !== 0 || rsp_data !== 16'h0) begin
      bad++; $display("FAIL mid_abort wr=%0d ram20=%h ram21=%h done=%0d rsp_data=%h required 1 0001 0000 0 0000",
                      wr_cnt, ram[16'h20], ram[16'h21], done_cnt, rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int ready_cyc = 0;
    int early = 0;
    int held_err = 0;
    for (int k = 0; k < 4; k++) ram[k] = 16'(k + 1);
    issue(2'b00, 16'h0007, 16'h0000, 16'h0000, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(2'b10, 16'h0000, 16'h0030, 16'h0000, 5'd2);
    cmd_op = 2'b00; cmd_addr = 16'h0031; cmd_valid = 1'b1;
    for (int c = 1; c <= 20 && ready_cyc == 0; c++) begin
      if (cmd_ready) ready_cyc = c;
      if (rsp_data !== 16'h1234) held_err++;
      if (c <= 5 && cmd_ready) early++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    total++;
    if (ready_cyc !== 6 || early !== 0) begin
      bad++; $display("FAIL b2b_ready first_ready_cycle=%0d early=%0d required 6 0", ready_cyc, early);
    end
    total++;
    if ({mem_read, mem_addr, rsp_data} !== {1'b1, 16'h0031, 16'h1234} || held_err !== 0) begin
      bad++; $display("FAIL b2b_load_cycle re=%b addr=%h rsp_data=%h held_err=%0d required 1 0031 1234 0",
                      mem_read, mem_addr, rsp_data, held_err);
    end
    @(posedge clk); #1;
    total++;
    if ({rsp_valid, done, rsp_data} !== {2'b11, 16'h0002}) begin
      bad++; $display("FAIL b2b_load_rsp rsp_valid=%b done=%b rsp_data=%h required 1 1 0002",
                      rsp_valid, done, rsp_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 65536; k++) ram[k] = 16'h0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_addr = 16'h0; cmd_addr2 = 16'h0; cmd_wdata = 16'h0; cmd_len = 5'd0;
    clear_mon();
    test_reset();
    test_store_load();
    test_copy();
    test_zero_len_reserved();
    test_wrap();
    test_reset_mid_copy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
